// File: rtl/prog_loader_pkg.sv
// Shared state encoding, widths and byte-joining helper for the Hack boot loader.
package prog_loader_pkg;

    localparam int unsigned HDR_BYTES = 2;
    localparam int unsigned WORD_W    = 16;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        CSUM_HI,
        CSUM_LO,
        RUN,
        ERR
    } state_t;

    // Stream words and the length header are both sent high byte first.
    function automatic logic [WORD_W-1:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
        logic [HDR_BYTES*8-1:0] w;
        w = {hi, lo};
        return WORD_W'(w);
    endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// once the count reaches TIMEOUT (only instantiated when TIMEOUT is non-zero).
module loader_timeout #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT));

    // Saturates at TIMEOUT so a stalled loader keeps reporting expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: byte stream -> 16-bit instruction memory writes, holding the CPU
// in reset until the image is complete. Define PROG_LOADER_CHECKSUM_EN for a checksum trailer.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned AW        = 15,
    parameter int unsigned MAX_WORDS = 32768,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reload,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM_HI;
`else
    localparam state_t AFTER_DATA = RUN;
`endif

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [WORD_W-1:0]   len_q, len_d;
    logic [WORD_W:0]     words_q, words_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   sum_q, sum_d;
`endif

    logic                accept;
    logic                tmo_en;
    logic                tmo_expired;
    logic [WORD_W-1:0]   rx_word;

    assign rx_ready = !reload && (state_q inside {HDR_HI, HDR_LO, DAT_HI, DAT_LO, CSUM_HI, CSUM_LO});
    assign accept   = rx_valid && rx_ready;
    assign tmo_en   = state_q inside {HDR_LO, DAT_HI, DAT_LO, CSUM_HI, CSUM_LO};
    assign rx_word  = join_bytes(hi_q, rx_data);

    generate
        if (TIMEOUT != 0) begin : g_tmo
            loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
                .clk     (clk),
                .reset   (reset),
                .clr     (accept || reload),
                .en      (tmo_en),
                .expired (tmo_expired)
            );
        end else begin : g_no_tmo
            assign tmo_expired = 1'b0;
        end
    endgenerate

    // Reload outranks everything; an accepted byte outranks a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        len_d     = len_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        if (reload) begin
            state_d   = HDR_HI;
            len_d     = '0;
            words_d   = '0;
            wr_addr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d     = '0;
`endif
        end else if (accept) begin
            case (state_q)
                HDR_HI: begin
                    hi_d    = rx_data;
                    state_d = HDR_LO;
                end
                HDR_LO: begin
                    len_d = rx_word;
                    if (32'(rx_word) > MAX_WORDS) begin
                        state_d = ERR;
                    end else if (rx_word == '0) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
                DAT_HI: begin
                    hi_d    = rx_data;
                    state_d = DAT_LO;
                end
                DAT_LO: begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rx_word;
                    wr_addr_d = AW'(words_q);
                    words_d   = words_q + (WORD_W + 1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + rx_word;
`endif
                    state_d   = (words_d == {1'b0, len_q}) ? AFTER_DATA : DAT_HI;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM_HI: begin
                    hi_d    = rx_data;
                    state_d = CSUM_LO;
                end
                CSUM_LO: begin
                    state_d = (rx_word == sum_q) ? RUN : ERR;
                end
`endif
                default: begin
                end
            endcase
        end else if (tmo_en && tmo_expired) begin
            state_d = ERR;
        end
    end

    // Status flags trail the state by one cycle so the last write lands before release.
    always_comb begin
        done_d      = (state_q == RUN) && !reload;
        error_d     = (state_q == ERR) && !reload;
        cpu_reset_d = !done_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HDR_HI;
            hi_q        <= '0;
            len_q       <= '0;
            words_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            len_q       <= len_d;
            words_q     <= words_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
